// File: rtl/wb_master_if.sv
// wb_master_if: bridges single CPU load/store requests onto a Wishbone master port.
//
// A request is latched in IDLE and issued as one Wishbone classic cycle. While
// it is outstanding, stallreq_o holds the pipeline. Read data is forwarded to
// the CPU in the ack cycle and also kept in a hold register. The hold register
// keeps the value visible while the pipeline is stalled (HOLD) and afterwards
// in IDLE. A flush during an outstanding cycle lets the bus cycle finish
// (DRAIN) but discards its result.
//
// Optional build macro WB_TIMEOUT_EN adds a 16-bit bus watchdog. When enabled,
// a cycle that waits TIMEOUT_CYCLES clocks without ack/err is terminated as if
// wb_err_i had been seen.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   stall_i         pipeline stall vector (non-zero = downstream stalled)
//   flush_i         pipeline flush
//   req_i, cpu_*_i  CPU access request: write enable, address, data, byte select
//   cpu_data_o      read data returned to the CPU
//   stallreq_o      stall request to the pipeline
//   bus_err_o       one-cycle bus error pulse
//   wb_*_o, wb_*_i  Wishbone master signals
module wb_master_if #(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter int STALL_W        = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               req_i,
  input  logic               cpu_we_i,
  input  logic [AW-1:0]      cpu_addr_i,
  input  logic [DW-1:0]      cpu_data_i,
  input  logic [DW/8-1:0]    cpu_sel_i,
  output logic [DW-1:0]      cpu_data_o,
  output logic               stallreq_o,
  output logic               bus_err_o,
  output logic [AW-1:0]      wb_addr_o,
  output logic [DW-1:0]      wb_data_o,
  output logic               wb_we_o,
  output logic [DW/8-1:0]    wb_sel_o,
  output logic               wb_stb_o,
  output logic               wb_cyc_o,
  input  logic [DW-1:0]      wb_data_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i
);

  if (DW != 8 && DW != 16 && DW != 32 && DW != 64) begin : g_bad_dw
    $error("wb_master_if: DW must be 8, 16, 32 or 64");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_master_if: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic              we_q;
  logic [DW/8-1:0]   sel_q;
  logic [DW-1:0]     hold_q, hold_d;
  logic              latch_en;
  logic              stall_req;
  logic              bus_err;
  logic [DW-1:0]     cpu_data;
  logic              on_bus;
  logic              timeout;
  logic              err_eff;
  logic              term;

  assign on_bus = (state_q == BUSY) || (state_q == DRAIN);

`ifdef WB_TIMEOUT_EN
  logic [15:0] wd_q;

  // Counts wait cycles of the current BUSY or DRAIN visit. Fires on the
  // TIMEOUT_CYCLES-th wait cycle, so cyc stays up exactly TIMEOUT_CYCLES clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else if ((state_d == BUSY || state_d == DRAIN) && state_d != state_q) begin
      wd_q <= '0;
    end else if (on_bus && !(wb_ack_i || wb_err_i)) begin
      wd_q <= wd_q + 16'd1;
    end
  end

  assign timeout = on_bus && (wd_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign err_eff = wb_err_i || timeout;
  assign term    = wb_ack_i || err_eff;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    latch_en  = 1'b0;
    stall_req = 1'b0;
    bus_err   = 1'b0;
    cpu_data  = hold_q;
    case (state_q)
      IDLE: begin
        stall_req = req_i;
        if (flush_i) begin
          hold_d = '0;
        end else if (req_i) begin
          latch_en = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (term) begin
          bus_err = err_eff;
          if (flush_i) begin
            hold_d  = '0;
            state_d = IDLE;
          end else begin
            // Error wins over a simultaneous ack: the CPU sees zero.
            hold_d   = err_eff ? '0 : wb_data_i;
            cpu_data = hold_d;
            state_d  = (|stall_i) ? HOLD : IDLE;
          end
        end else begin
          stall_req = 1'b1;
          // cyc/stb must not drop mid-cycle, so wait out the slave in DRAIN.
          if (flush_i) begin
            hold_d  = '0;
            state_d = DRAIN;
          end
        end
      end
      HOLD: begin
        if (flush_i) begin
          hold_d  = '0;
          state_d = IDLE;
        end else if (stall_i == '0) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        stall_req = req_i;
        if (term) begin
          bus_err = timeout;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (latch_en) begin
        addr_q  <= cpu_addr_i;
        wdata_q <= cpu_data_i;
        we_q    <= cpu_we_i;
        sel_q   <= cpu_sel_i;
      end
    end
  end

  // stallreq_o follows req_i combinationally in IDLE, so gate it while in reset.
  assign stallreq_o = rst && stall_req;
  assign bus_err_o  = bus_err;
  assign cpu_data_o = cpu_data;
  assign wb_cyc_o   = on_bus;
  assign wb_stb_o   = on_bus;
  assign wb_addr_o  = addr_q;
  assign wb_data_o  = wdata_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q && (state_q == BUSY);

endmodule

// File: tb/tb_wb_master_if.sv
module tb_wb_master_if;

  localparam int TO = 8;
`ifdef WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i, req_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_data_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o, bus_err_o;
  logic [31:0] wb_addr_o, wb_data_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i, wb_err_i;

  logic        rst64;
  logic [5:0]  stall64;
  logic        flush64, req64, we64, ack64, err64;
  logic [31:0] addr64, waddr64;
  logic [63:0] cdata64, cpu_data64, wdata64, rdata64;
  logic [7:0]  sel64, wsel64;
  logic        srq64, berr64, wwe64, stb64, cyc64;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_master_if #(.DW(32), .AW(32), .STALL_W(6), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .req_i(req_i),
    .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o),
    .bus_err_o(bus_err_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  wb_master_if #(.DW(64), .AW(32), .STALL_W(6), .TIMEOUT_CYCLES(TO)) u_dut64 (
    .clk(clk), .rst(rst64), .stall_i(stall64), .flush_i(flush64), .req_i(req64),
    .cpu_we_i(we64), .cpu_addr_i(addr64), .cpu_data_i(cdata64),
    .cpu_sel_i(sel64), .cpu_data_o(cpu_data64), .stallreq_o(srq64),
    .bus_err_o(berr64), .wb_addr_o(waddr64), .wb_data_o(wdata64),
    .wb_we_o(wwe64), .wb_sel_o(wsel64), .wb_stb_o(stb64), .wb_cyc_o(cyc64),
    .wb_data_i(rdata64), .wb_ack_i(ack64), .wb_err_i(err64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        req, we, flush, ack, err;
    logic [31:0] addr, wdata, rdata;
    logic [5:0]  stall;
    logic        exp_cyc, exp_srq, exp_berr, exp_we;
    logic [31:0] exp_cpu;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [5:0] stall,
                              input logic flush, input logic ack, input logic err,
                              input logic [31:0] rdata, input logic cyc, input logic srq,
                              input logic berr, input logic weo, input logic [31:0] cpu);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.stall = stall;
    v.flush = flush; v.ack = ack; v.err = err; v.rdata = rdata;
    v.exp_cyc = cyc; v.exp_srq = srq; v.exp_berr = berr; v.exp_we = weo; v.exp_cpu = cpu;
    return v;
  endfunction

  vec_t tbl[24];

  // Reference model state: outstanding bus cycle, result to be discarded,
  // CPU held with returned data, and the values visible to the CPU and bus.
  bit          m_pend, m_disc, m_holding;
  int          m_wait;
  logic [31:0] m_hold, m_addr, m_data;
  logic        m_we;
  logic [3:0]  m_sel;

  task automatic idle_inputs();
    req_i = 0; cpu_we_i = 0; cpu_addr_i = 0; cpu_data_i = 0; cpu_sel_i = 4'hF;
    stall_i = 0; flush_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_data_i = 0;
  endtask

  initial begin
    int cyc_cnt, err_cnt;
    bit to_hit, errx, term;
    logic        e_srq, e_berr, e_we;
    logic [31:0] e_cpu;

    idle_inputs();
    req64 = 0; we64 = 0; addr64 = 0; cdata64 = 0; sel64 = 0; stall64 = 0;
    flush64 = 0; ack64 = 0; err64 = 0; rdata64 = 0;
    rst = 1; rst64 = 1;
    #2;
    rst = 0; rst64 = 0;
    req_i = 1;
    #1;
    chk("rst_stallreq", stallreq_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_cpu_data", cpu_data_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    req_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1; rst64 = 1;
    @(posedge clk); #1;

    // Directed cycle-by-cycle vectors
    tbl[0]  = mk(1,0,32'h100,0,0,0,0,0,0,                 0,1,0,0,0);
    tbl[1]  = mk(1,0,32'h100,0,0,0,0,0,0,                 1,1,0,0,0);
    tbl[2]  = mk(1,0,32'h100,0,0,0,0,0,0,                 1,1,0,0,0);
    tbl[3]  = mk(1,0,32'h100,0,6'b000100,0,1,0,32'hDEADBEEF, 1,0,0,0,32'hDEADBEEF);
    tbl[4]  = mk(0,0,0,0,6'b000100,0,0,0,0,               0,0,0,0,32'hDEADBEEF);
    tbl[5]  = mk(0,0,0,0,6'b000100,0,0,0,0,               0,0,0,0,32'hDEADBEEF);
    tbl[6]  = mk(0,0,0,0,6'b000100,0,0,0,0,               0,0,0,0,32'hDEADBEEF);
    tbl[7]  = mk(0,0,0,0,0,0,0,0,0,                       0,0,0,0,32'hDEADBEEF);
    tbl[8]  = mk(0,0,0,0,0,0,0,0,0,                       0,0,0,0,32'hDEADBEEF);
    tbl[9]  = mk(1,1,32'h200,32'h12345678,0,0,0,0,0,      0,1,0,0,32'hDEADBEEF);
    tbl[10] = mk(0,1,32'h200,32'h12345678,0,0,0,0,0,      1,1,0,1,32'hDEADBEEF);
    tbl[11] = mk(0,0,0,0,0,1,0,0,0,                       1,1,0,1,32'hDEADBEEF);
    tbl[12] = mk(0,0,0,0,0,0,0,0,0,                       1,0,0,0,0);
    tbl[13] = mk(0,0,0,0,0,0,0,0,0,                       1,0,0,0,0);
    tbl[14] = mk(0,0,0,0,0,0,1,0,32'hAAAA5555,            1,0,0,0,0);
    tbl[15] = mk(0,0,0,0,0,0,0,0,0,                       0,0,0,0,0);
    tbl[16] = mk(1,0,32'h300,0,0,0,0,0,0,                 0,1,0,0,0);
    tbl[17] = mk(0,0,0,0,0,0,1,1,32'h55,                  1,0,1,0,0);
    tbl[18] = mk(0,0,0,0,0,0,0,0,0,                       0,0,0,0,0);
    tbl[19] = mk(1,0,32'h400,0,0,0,0,0,0,                 0,1,0,0,0);
    tbl[20] = mk(0,0,0,0,0,0,1,0,32'hCAFEF00D,            1,0,0,0,32'hCAFEF00D);
    tbl[21] = mk(0,0,0,0,0,0,0,0,0,                       0,0,0,0,32'hCAFEF00D);
    tbl[22] = mk(0,0,0,0,0,1,0,0,0,                       0,0,0,0,32'hCAFEF00D);
    tbl[23] = mk(0,0,0,0,0,0,0,0,0,                       0,0,0,0,0);

    for (int i = 0; i < 24; i++) begin
      req_i = tbl[i].req; cpu_we_i = tbl[i].we; cpu_addr_i = tbl[i].addr;
      cpu_data_i = tbl[i].wdata; stall_i = tbl[i].stall; flush_i = tbl[i].flush;
      wb_ack_i = tbl[i].ack; wb_err_i = tbl[i].err; wb_data_i = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("row%0d_cyc", i), wb_cyc_o, tbl[i].exp_cyc);
      chk($sformatf("row%0d_stb", i), wb_stb_o, tbl[i].exp_cyc);
      chk($sformatf("row%0d_stallreq", i), stallreq_o, tbl[i].exp_srq);
      chk($sformatf("row%0d_bus_err", i), bus_err_o, tbl[i].exp_berr);
      chk($sformatf("row%0d_we", i), wb_we_o, tbl[i].exp_we);
      chk($sformatf("row%0d_cpu_data", i), cpu_data_o, tbl[i].exp_cpu);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Slave that never answers
    req_i = 1; cpu_addr_i = 32'h500;
    @(posedge clk); #1;
    req_i = 0;
    cyc_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (wb_cyc_o) cyc_cnt++;
      if (bus_err_o) err_cnt++;
      @(posedge clk); #1;
      if (!wb_cyc_o) break;
    end
    if (TO_EN) begin
      chk("timeout_cyc_cycles", cyc_cnt, TO);
      chk("timeout_err_pulses", err_cnt, 1);
      chk("timeout_cpu_data", cpu_data_o, 0);
    end else begin
      chk("no_timeout_cyc_cycles", cyc_cnt, 1000);
      chk("no_timeout_err_pulses", err_cnt, 0);
      chk("no_timeout_still_cyc", wb_cyc_o, 1);
      wb_ack_i = 1; wb_data_i = 32'h0BADF00D;
      @(negedge clk);
      chk("late_ack_cpu_data", cpu_data_o, 32'h0BADF00D);
      @(posedge clk); #1;
      wb_ack_i = 0;
      chk("late_ack_cyc_drop", wb_cyc_o, 0);
    end
    idle_inputs();

    // 64-bit write abandoned by reset mid-cycle
    req64 = 1; we64 = 1; sel64 = 8'h0F; addr64 = 32'h40; cdata64 = 64'h1122334455667788;
    @(posedge clk); #1;
    chk("w64_cyc", cyc64, 1);
    chk("w64_we", wwe64, 1);
    chk("w64_sel", wsel64, 8'h0F);
    chk("w64_data", wdata64, 64'h1122334455667788);
    rst64 = 0; err64 = 1;
    #1;
    chk("w64rst_cyc", cyc64, 0);
    chk("w64rst_stb", stb64, 0);
    chk("w64rst_we", wwe64, 0);
    chk("w64rst_sel", wsel64, 0);
    chk("w64rst_addr", waddr64, 0);
    chk("w64rst_wdata", wdata64, 0);
    chk("w64rst_cpu_data", cpu_data64, 0);
    chk("w64rst_stallreq", srq64, 0);
    chk("w64rst_bus_err", berr64, 0);
    @(negedge clk);
    rst64 = 1; err64 = 0; req64 = 0;
    @(posedge clk); #1;
    chk("w64post_cyc", cyc64, 0);
    chk("w64post_bus_err", berr64, 0);
    req64 = 1;
    #1;
    chk("w64post_idle_stallreq", srq64, 1);
    req64 = 0;

    // Randomized run against the reference model
    rst = 0;
    @(negedge clk);
    rst = 1;
    m_pend = 0; m_disc = 0; m_holding = 0; m_wait = 0;
    m_hold = 0; m_addr = 0; m_data = 0; m_we = 0; m_sel = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      req_i      = ($urandom_range(1) == 1);
      cpu_we_i   = ($urandom_range(1) == 1);
      cpu_addr_i = $urandom;
      cpu_data_i = $urandom;
      cpu_sel_i  = 4'($urandom_range(15));
      stall_i    = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'd0;
      flush_i    = ($urandom_range(15) == 0);
      wb_ack_i   = ($urandom_range(2) == 0);
      wb_err_i   = ($urandom_range(11) == 0);
      wb_data_i  = $urandom;
      @(negedge clk);
      to_hit = TO_EN && m_pend && (m_wait == TO - 1);
      errx   = wb_err_i || to_hit;
      term   = m_pend && (wb_ack_i || errx);
      e_we   = m_pend && !m_disc && m_we;
      e_berr = m_pend && (m_disc ? to_hit : errx);
      e_srq  = m_pend ? (m_disc ? req_i : !term) : (m_holding ? 1'b0 : req_i);
      e_cpu  = (m_pend && !m_disc && term && !flush_i) ? (errx ? 32'd0 : wb_data_i) : m_hold;
      chk("rnd_cyc", wb_cyc_o, m_pend);
      chk("rnd_stb", wb_stb_o, m_pend);
      chk("rnd_stallreq", stallreq_o, e_srq);
      chk("rnd_bus_err", bus_err_o, e_berr);
      chk("rnd_cpu_data", cpu_data_o, e_cpu);
      chk("rnd_we", wb_we_o, e_we);
      chk("rnd_addr", wb_addr_o, m_addr);
      chk("rnd_wdata", wb_data_o, m_data);
      chk("rnd_sel", wb_sel_o, m_sel);
      if (m_pend) begin
        if (term) begin
          if (!m_disc) begin
            if (flush_i) m_hold = 0;
            else begin
              m_hold    = errx ? 32'd0 : wb_data_i;
              m_holding = (stall_i != 0);
            end
          end
          m_pend = 0; m_disc = 0;
        end else if (flush_i && !m_disc) begin
          m_disc = 1; m_hold = 0; m_wait = 0;
        end else begin
          m_wait++;
        end
      end else if (m_holding) begin
        if (flush_i) begin m_hold = 0; m_holding = 0; end
        else if (stall_i == 0) m_holding = 0;
      end else if (flush_i) begin
        m_hold = 0;
      end else if (req_i) begin
        m_pend = 1; m_disc = 0; m_wait = 0;
        m_addr = cpu_addr_i; m_data = cpu_data_i; m_we = cpu_we_i; m_sel = cpu_sel_i;
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
